// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port word RAM between fetch and LSU.
// Byte-masked stores are done as a two-cycle read-modify-write.
module ram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int PRIO_INIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_we,
    input  logic [1:0][3:0]        req_be,
    input  logic [1:0][ADDR_W-1:0] req_addr,
    input  logic [1:0][DATA_W-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [1:0][DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_d,
    output logic                   ram_we,
    input  logic [DATA_W-1:0]      ram_q
);

    typedef enum logic {IDLE, RMW} state_t;

    state_t              state;
    logic                prio;
    logic                lport;
    logic [ADDR_W-1:0]   laddr;
    logic [DATA_W-1:0]   ldata;
    logic [DATA_W-1:0]   lold;
    logic [3:0]          lbe;

    logic                gnt;
    logic                gp;
    logic [3:0]          gbe;
    logic                full;
    logic                part;
    logic [DATA_W-1:0]   mrg;

    always_comb begin
        req_ready = '0;
        gnt       = 1'b0;
        gp        = 1'b0;
        if (!rst && state == IDLE) begin
            gp  = (req_valid == 2'b11) ? prio : req_valid[1];
            gnt = |req_valid;
            req_ready[gp] = gnt;
        end
        gbe  = req_be[gp];
        full = (gbe == 4'hF);
        part = !full && (gbe != 4'h0);
    end

    always_comb begin
        mrg = lold;
        for (int i = 0; i < 4; i++) begin
            if (lbe[i]) mrg[8*i +: 8] = ldata[8*i +: 8];
        end
    end

    // RAM side is combinational so a read completes within the grant cycle
    always_comb begin
        ram_addr = '0;
        ram_d    = '0;
        ram_we   = 1'b0;
        if (gnt) begin
            ram_addr = req_addr[gp];
            if (req_we[gp] && full) begin
                ram_we = 1'b1;
                ram_d  = req_wdata[gp];
            end
        end else if (!rst && state == RMW) begin
            ram_addr = laddr;
            ram_we   = 1'b1;
            ram_d    = mrg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            prio      <= 1'(PRIO_INIT);
            rsp_valid <= '0;
            rsp_rdata <= '0;
            lport     <= 1'b0;
            laddr     <= '0;
            ldata     <= '0;
            lold      <= '0;
            lbe       <= '0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (gnt) begin
                        prio <= ~gp;
                        if (req_we[gp] && part) begin
                            state <= RMW;
                            lport <= gp;
                            laddr <= req_addr[gp];
                            ldata <= req_wdata[gp];
                            lold  <= ram_q;
                            lbe   <= gbe;
                        end else begin
                            rsp_valid[gp] <= 1'b1;
                            if (!req_we[gp]) rsp_rdata[gp] <= ram_q;
                        end
                    end
                end
                RMW: begin
                    state            <= IDLE;
                    rsp_valid[lport] <= 1'b1;
                end
            endcase
        end
    end

endmodule
